// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator host sequencer: accelerator register
// indices, control/status bit positions and the sequencer state encoding.
package accel_pkg;

    localparam int unsigned REG_SRC    = 0;
    localparam int unsigned REG_DST    = 1;
    localparam int unsigned REG_LEN    = 2;
    localparam int unsigned REG_CTRL   = 3;
    localparam int unsigned REG_STATUS = 4;

    localparam int unsigned CTRL_GO_BIT     = 0;
    localparam int unsigned STATUS_DONE_BIT = 0;

    typedef enum logic [2:0] {
        IDLE,
        WR_SRC,
        WR_DST,
        WR_LEN,
        WR_CTRL,
        WAIT_DONE,
        POLL_RD,
        FIN
    } state_e;

endpackage

// File: rtl/accel_host_seq_if.sv
// Avalon-MM bus between the host sequencer (master) and the accelerator's
// register slave.
interface accel_host_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/accel_host_seq.sv
// Host-side job sequencer: programs SRC/DST/LEN, sets CTRL.go, then waits for
// completion (done pin or STATUS polling) with a cycle counter and timeout abort.
module accel_host_seq
    import accel_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 4,
    parameter int TIMEOUT      = 1000000,
    parameter int USE_DONE_PIN = 1
) (
    input  logic              csi_clock_clk,
    input  logic              csi_clock_reset,
    input  logic              start,
    input  logic [DATA_W-1:0] src_addr,
    input  logic [DATA_W-1:0] dst_addr,
    input  logic [DATA_W-1:0] length,
    input  logic              done_in,
    accel_host_seq_if.master  bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       cycles
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] src_q, src_d;
    logic [DATA_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] len_q, len_d;
    logic [31:0]       cycles_q, cycles_d;
    logic              error_q, error_d;
    logic              pollGap_q, pollGap_d;

    logic [ADDR_W-1:0] cmdAddr;
    logic              cmdRead;
    logic              cmdWrite;
    logic [DATA_W-1:0] cmdData;
    logic              busyNow;
    logic              timeoutHit;

    assign busyNow = (state_q != IDLE) && (state_q != FIN);
    // Abort in the busy cycle that brings the counter up to TIMEOUT.
    assign timeoutHit = busyNow && (({1'b0, cycles_q} + 33'd1) >= 33'(TIMEOUT));

    always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
        if (csi_clock_reset) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            cycles_q  <= '0;
            error_q   <= 1'b0;
            pollGap_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            cycles_q  <= cycles_d;
            error_q   <= error_d;
            pollGap_q <= pollGap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        cycles_d  = cycles_q;
        error_d   = error_q;
        pollGap_d = pollGap_q;
        cmdAddr   = '0;
        cmdRead   = 1'b0;
        cmdWrite  = 1'b0;
        cmdData   = '0;

        if (busyNow && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_d = cycles_q + 32'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cycles_d  = '0;
                    error_d   = 1'b0;
                    pollGap_d = 1'b0;
                    if (length != '0) begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        len_d   = length;
                        state_d = WR_SRC;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            WR_SRC: begin
                cmdWrite = 1'b1;
                cmdAddr  = ADDR_W'(REG_SRC);
                cmdData  = src_q;
                if (!bus.avm_waitrequest) state_d = WR_DST;
            end
            WR_DST: begin
                cmdWrite = 1'b1;
                cmdAddr  = ADDR_W'(REG_DST);
                cmdData  = dst_q;
                if (!bus.avm_waitrequest) state_d = WR_LEN;
            end
            WR_LEN: begin
                cmdWrite = 1'b1;
                cmdAddr  = ADDR_W'(REG_LEN);
                cmdData  = len_q;
                if (!bus.avm_waitrequest) state_d = WR_CTRL;
            end
            WR_CTRL: begin
                cmdWrite             = 1'b1;
                cmdAddr              = ADDR_W'(REG_CTRL);
                cmdData[CTRL_GO_BIT] = 1'b1;
                if (!bus.avm_waitrequest) begin
                    state_d = (USE_DONE_PIN != 0) ? WAIT_DONE : POLL_RD;
                end
            end
            WAIT_DONE: begin
                if (done_in) state_d = FIN;
            end
            POLL_RD: begin
                // pollGap_q marks the single idle cycle between two STATUS reads.
                if (pollGap_q) begin
                    pollGap_d = 1'b0;
                end else begin
                    cmdRead = 1'b1;
                    cmdAddr = ADDR_W'(REG_STATUS);
                    if (!bus.avm_waitrequest) begin
                        if (bus.avm_readdata[STATUS_DONE_BIT]) state_d = FIN;
                        else                                   pollGap_d = 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (timeoutHit) begin
            cmdAddr   = '0;
            cmdRead   = 1'b0;
            cmdWrite  = 1'b0;
            cmdData   = '0;
            error_d   = 1'b1;
            pollGap_d = 1'b0;
            state_d   = FIN;
        end
    end

    assign bus.avm_address   = cmdAddr;
    assign bus.avm_read      = cmdRead;
    assign bus.avm_write     = cmdWrite;
    assign bus.avm_writedata = cmdData;

    assign busy   = busyNow;
    assign done   = (state_q == FIN);
    assign error  = error_q;
    assign cycles = cycles_q;

endmodule

// File: tb/tb_accel_host_seq.sv
// Directed bench for accel_host_seq: three instances cover done-pin mode,
// STATUS polling mode and a short TIMEOUT.
module tb_accel_host_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] srcAddr = '0;
    logic [31:0] dstAddr = '0;
    logic [31:0] len = '0;
    logic        doneIn = 1'b0;

    logic        busy0, done0, error0;
    logic        busy1, done1, error1;
    logic        busy2, done2, error2;
    logic [31:0] cycles0, cycles1, cycles2;

    int checks = 0;
    int errors = 0;

    accel_host_seq_if #(.DATA_W(32), .ADDR_W(4)) bus0 ();
    accel_host_seq_if #(.DATA_W(32), .ADDR_W(4)) bus1 ();
    accel_host_seq_if #(.DATA_W(32), .ADDR_W(4)) bus2 ();

    accel_host_seq #(.DATA_W(32), .ADDR_W(4), .TIMEOUT(1000000), .USE_DONE_PIN(1)) dut0 (
        .csi_clock_clk(clk), .csi_clock_reset(rst), .start(start),
        .src_addr(srcAddr), .dst_addr(dstAddr), .length(len), .done_in(doneIn),
        .bus(bus0), .busy(busy0), .done(done0), .error(error0), .cycles(cycles0)
    );

    accel_host_seq #(.DATA_W(32), .ADDR_W(4), .TIMEOUT(1000000), .USE_DONE_PIN(0)) dut1 (
        .csi_clock_clk(clk), .csi_clock_reset(rst), .start(start),
        .src_addr(srcAddr), .dst_addr(dstAddr), .length(len), .done_in(doneIn),
        .bus(bus1), .busy(busy1), .done(done1), .error(error1), .cycles(cycles1)
    );

    accel_host_seq #(.DATA_W(32), .ADDR_W(4), .TIMEOUT(50), .USE_DONE_PIN(1)) dut2 (
        .csi_clock_clk(clk), .csi_clock_reset(rst), .start(start),
        .src_addr(srcAddr), .dst_addr(dstAddr), .length(len), .done_in(doneIn),
        .bus(bus2), .busy(busy2), .done(done2), .error(error2), .cycles(cycles2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        start = 1'b0;
        doneIn = 1'b0;
        srcAddr = '0;
        dstAddr = '0;
        len = '0;
        bus0.avm_waitrequest = 1'b0;
        bus1.avm_waitrequest = 1'b0;
        bus2.avm_waitrequest = 1'b0;
        bus0.avm_readdata = '0;
        bus1.avm_readdata = '0;
        bus2.avm_readdata = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Start is sampled at "edge 0"; on return the bench sits in cycle 1.
    task automatic startJob(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        srcAddr = s;
        dstAddr = d;
        len = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        bus0.avm_waitrequest = 1'b0;
        bus1.avm_waitrequest = 1'b0;
        bus2.avm_waitrequest = 1'b0;
        bus0.avm_readdata = '0;
        bus1.avm_readdata = '0;
        bus2.avm_readdata = '0;
        tick();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got %b expected 0", done0); end
        checks++; if (error0 !== 1'b0) begin errors++; $display("[TB] FAIL rst_error: got %b expected 0", error0); end
        checks++; if (cycles0 !== 32'd0) begin errors++; $display("[TB] FAIL rst_cycles: got %0h expected 0", cycles0); end
        checks++; if (bus0.avm_write !== 1'b0) begin errors++; $display("[TB] FAIL rst_write: got %b expected 0", bus0.avm_write); end
        checks++; if (bus0.avm_read !== 1'b0) begin errors++; $display("[TB] FAIL rst_read: got %b expected 0", bus0.avm_read); end
        checks++; if (bus0.avm_address !== 4'd0) begin errors++; $display("[TB] FAIL rst_addr: got %0h expected 0", bus0.avm_address); end
        checks++; if (bus0.avm_writedata !== 32'd0) begin errors++; $display("[TB] FAIL rst_wdata: got %0h expected 0", bus0.avm_writedata); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy1: got %b expected 0", busy1); end
        checks++; if (error2 !== 1'b0) begin errors++; $display("[TB] FAIL rst_error2: got %b expected 0", error2); end
        rst = 1'b0;
        tick();
    endtask

    // Done-pin job; done_in pulsed during WR_DST and a second start while busy must both be ignored.
    task automatic test_done_pin();
        logic [31:0] expData [4];
        expData[0] = 32'h1000; expData[1] = 32'h2000; expData[2] = 32'd16; expData[3] = 32'd1;
        applyReset();
        startJob(32'h1000, 32'h2000, 32'd16);
        for (int k = 1; k <= 22; k++) begin
            if (k <= 4) begin
                checks++; if (bus0.avm_write !== 1'b1) begin errors++; $display("[TB] FAIL s1_write cyc%0d: got %b expected 1", k, bus0.avm_write); end
                checks++; if (bus0.avm_address !== 4'(k - 1)) begin errors++; $display("[TB] FAIL s1_addr cyc%0d: got %0h expected %0h", k, bus0.avm_address, k - 1); end
                checks++; if (bus0.avm_writedata !== expData[k-1]) begin errors++; $display("[TB] FAIL s1_wdata cyc%0d: got %0h expected %0h", k, bus0.avm_writedata, expData[k-1]); end
            end else begin
                checks++; if (bus0.avm_write !== 1'b0) begin errors++; $display("[TB] FAIL s1_write cyc%0d: got %b expected 0", k, bus0.avm_write); end
            end
            checks++; if (bus0.avm_read !== 1'b0) begin errors++; $display("[TB] FAIL s1_read cyc%0d: got %b expected 0", k, bus0.avm_read); end
            checks++; if (busy0 !== (k <= 20)) begin errors++; $display("[TB] FAIL s1_busy cyc%0d: got %b expected %b", k, busy0, (k <= 20)); end
            checks++; if (done0 !== (k == 21)) begin errors++; $display("[TB] FAIL s1_done cyc%0d: got %b expected %b", k, done0, (k == 21)); end
            if (k >= 21) begin
                checks++; if (cycles0 !== 32'd20) begin errors++; $display("[TB] FAIL s1_cycles cyc%0d: got %0d expected 20", k, cycles0); end
                checks++; if (error0 !== 1'b0) begin errors++; $display("[TB] FAIL s1_error cyc%0d: got %b expected 0", k, error0); end
            end
            if (k == 2) doneIn = 1'b1;
            if (k == 3) doneIn = 1'b0;
            if (k == 10) begin start = 1'b1; srcAddr = 32'hDEAD; len = 32'd5; end
            if (k == 11) start = 1'b0;
            if (k == 20) doneIn = 1'b1;
            if (k == 21) doneIn = 1'b0;
            tick();
        end
    endtask

    // Waitrequest high for three cycles on every write: each write spans four cycles.
    task automatic test_wait_request();
        logic [31:0] expData [4];
        int w;
        expData[0] = 32'hA; expData[1] = 32'hB; expData[2] = 32'hC; expData[3] = 32'd1;
        applyReset();
        bus0.avm_waitrequest = 1'b1;
        startJob(32'hA, 32'hB, 32'hC);
        for (int k = 1; k <= 18; k++) begin
            bus0.avm_waitrequest = (k <= 16) && ((k % 4) != 0);
            if (k <= 16) begin
                w = (k - 1) / 4;
                checks++; if (bus0.avm_write !== 1'b1) begin errors++; $display("[TB] FAIL s2_write cyc%0d: got %b expected 1", k, bus0.avm_write); end
                checks++; if (bus0.avm_address !== 4'(w)) begin errors++; $display("[TB] FAIL s2_addr cyc%0d: got %0h expected %0h", k, bus0.avm_address, w); end
                checks++; if (bus0.avm_writedata !== expData[w]) begin errors++; $display("[TB] FAIL s2_wdata cyc%0d: got %0h expected %0h", k, bus0.avm_writedata, expData[w]); end
            end else begin
                checks++; if (bus0.avm_write !== 1'b0) begin errors++; $display("[TB] FAIL s2_write cyc%0d: got %b expected 0", k, bus0.avm_write); end
            end
            if (k == 17) begin
                checks++; if (busy0 !== 1'b1) begin errors++; $display("[TB] FAIL s2_busy cyc17: got %b expected 1", busy0); end
                doneIn = 1'b1;
            end
            if (k == 18) begin
                checks++; if (done0 !== 1'b1) begin errors++; $display("[TB] FAIL s2_done cyc18: got %b expected 1", done0); end
                checks++; if (cycles0 !== 32'd17) begin errors++; $display("[TB] FAIL s2_cycles cyc18: got %0d expected 17", cycles0); end
                doneIn = 1'b0;
            end
            tick();
        end
    endtask

    // STATUS polling: reads at cycles 5, 7, 9 (bit0 = 0, 0, 1), done pulse at cycle 10.
    task automatic test_poll();
        int readCount = 0;
        logic expRead;
        applyReset();
        startJob(32'h100, 32'h200, 32'h40);
        for (int k = 1; k <= 11; k++) begin
            bus1.avm_readdata = (k == 5) ? 32'hFFFF_FFFE : (k == 7) ? 32'h2 : (k == 9) ? 32'h1 : 32'h0;
            expRead = (k == 5) || (k == 7) || (k == 9);
            if (bus1.avm_read === 1'b1) readCount++;
            checks++; if (bus1.avm_read !== expRead) begin errors++; $display("[TB] FAIL s3_read cyc%0d: got %b expected %b", k, bus1.avm_read, expRead); end
            if (expRead) begin
                checks++; if (bus1.avm_address !== 4'd4) begin errors++; $display("[TB] FAIL s3_addr cyc%0d: got %0h expected 4", k, bus1.avm_address); end
            end
            checks++; if (bus1.avm_write !== (k <= 4)) begin errors++; $display("[TB] FAIL s3_write cyc%0d: got %b expected %b", k, bus1.avm_write, (k <= 4)); end
            checks++; if ((bus1.avm_read & bus1.avm_write) !== 1'b0) begin errors++; $display("[TB] FAIL s3_rw_excl cyc%0d: got 1 expected 0", k); end
            checks++; if (busy1 !== (k <= 9)) begin errors++; $display("[TB] FAIL s3_busy cyc%0d: got %b expected %b", k, busy1, (k <= 9)); end
            checks++; if (done1 !== (k == 10)) begin errors++; $display("[TB] FAIL s3_done cyc%0d: got %b expected %b", k, done1, (k == 10)); end
            if (k == 10) begin
                checks++; if (cycles1 !== 32'd9) begin errors++; $display("[TB] FAIL s3_cycles: got %0d expected 9", cycles1); end
            end
            tick();
        end
        checks++; if (readCount !== 3) begin errors++; $display("[TB] FAIL s3_read_count: got %0d expected 3", readCount); end
    endtask

    // Short TIMEOUT with the bus stalled, then restart with len=0 and with a real job.
    task automatic test_timeout();
        applyReset();
        bus2.avm_waitrequest = 1'b1;
        startJob(32'h5, 32'h6, 32'h7);
        for (int k = 1; k <= 52; k++) begin
            checks++; if (bus2.avm_write !== (k <= 49)) begin errors++; $display("[TB] FAIL s5_write cyc%0d: got %b expected %b", k, bus2.avm_write, (k <= 49)); end
            checks++; if (busy2 !== (k <= 50)) begin errors++; $display("[TB] FAIL s5_busy cyc%0d: got %b expected %b", k, busy2, (k <= 50)); end
            checks++; if (done2 !== (k == 51)) begin errors++; $display("[TB] FAIL s5_done cyc%0d: got %b expected %b", k, done2, (k == 51)); end
            if (k >= 51) begin
                checks++; if (error2 !== 1'b1) begin errors++; $display("[TB] FAIL s5_error cyc%0d: got %b expected 1", k, error2); end
                checks++; if (cycles2 !== 32'd50) begin errors++; $display("[TB] FAIL s5_cycles cyc%0d: got %0d expected 50", k, cycles2); end
            end
            tick();
        end
        bus2.avm_waitrequest = 1'b0;
        startJob(32'h5, 32'h6, 32'h0);
        checks++; if (done2 !== 1'b1) begin errors++; $display("[TB] FAIL s5_len0_done: got %b expected 1", done2); end
        checks++; if (error2 !== 1'b0) begin errors++; $display("[TB] FAIL s5_len0_error: got %b expected 0", error2); end
        checks++; if (cycles2 !== 32'd0) begin errors++; $display("[TB] FAIL s5_len0_cycles: got %0d expected 0", cycles2); end
        checks++; if (bus2.avm_write !== 1'b0) begin errors++; $display("[TB] FAIL s5_len0_write: got %b expected 0", bus2.avm_write); end
        tick();
        startJob(32'h5, 32'h6, 32'h7);
        checks++; if (busy2 !== 1'b1) begin errors++; $display("[TB] FAIL s5_restart_busy: got %b expected 1", busy2); end
        checks++; if (bus2.avm_write !== 1'b1) begin errors++; $display("[TB] FAIL s5_restart_write: got %b expected 1", bus2.avm_write); end
        checks++; if (error2 !== 1'b0) begin errors++; $display("[TB] FAIL s5_restart_error: got %b expected 0", error2); end
    endtask

    task automatic test_zero_length();
        applyReset();
        startJob(32'h11, 32'h22, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            checks++; if (bus0.avm_write !== 1'b0) begin errors++; $display("[TB] FAIL s4_write cyc%0d: got %b expected 0", k, bus0.avm_write); end
            checks++; if (bus0.avm_read !== 1'b0) begin errors++; $display("[TB] FAIL s4_read cyc%0d: got %b expected 0", k, bus0.avm_read); end
            checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL s4_busy cyc%0d: got %b expected 0", k, busy0); end
            checks++; if (done0 !== (k == 1)) begin errors++; $display("[TB] FAIL s4_done cyc%0d: got %b expected %b", k, done0, (k == 1)); end
            checks++; if (cycles0 !== 32'd0) begin errors++; $display("[TB] FAIL s4_cycles cyc%0d: got %0d expected 0", k, cycles0); end
            tick();
        end
    endtask

    // Asynchronous reset while WR_LEN is on the bus.
    task automatic test_reset_midway();
        applyReset();
        startJob(32'h1, 32'h2, 32'h3);
        tick();
        tick();
        checks++; if (bus0.avm_address !== 4'd2) begin errors++; $display("[TB] FAIL s6_wrlen_addr: got %0h expected 2", bus0.avm_address); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus0.avm_write !== 1'b0) begin errors++; $display("[TB] FAIL s6_write: got %b expected 0", bus0.avm_write); end
        checks++; if (bus0.avm_address !== 4'd0) begin errors++; $display("[TB] FAIL s6_addr: got %0h expected 0", bus0.avm_address); end
        checks++; if (bus0.avm_writedata !== 32'd0) begin errors++; $display("[TB] FAIL s6_wdata: got %0h expected 0", bus0.avm_writedata); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL s6_busy: got %b expected 0", busy0); end
        checks++; if (cycles0 !== 32'd0) begin errors++; $display("[TB] FAIL s6_cycles: got %0d expected 0", cycles0); end
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL s6_done cyc%0d: got %b expected 0", k, done0); end
            checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL s6_idle_busy cyc%0d: got %b expected 0", k, busy0); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_done_pin();
        test_wait_request();
        test_poll();
        test_timeout();
        test_zero_length();
        test_reset_midway();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
